// File: rtl/add16_seq.sv
// add16_seq: 16-bit adder that sums two operands four bits at a time through
// a single 4-bit adder. A start in IDLE latches the operands, four RUN cycles
// walk the nibbles LSB first with a rippling carry register, and a one-cycle
// DONE state presents the registered result, carry-out and overflow flag.

// Plain 4-bit adder with carry in and carry out.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       i_c,
  output logic [3:0] sum,
  output logic       o_c
);

  assign {o_c, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, i_c};

endmodule

module add16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        c_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        c_out,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [15:0] a_r;
  logic [15:0] b_r;
  logic        carry_r;
  logic [1:0]  cnt_r;
  logic [15:0] acc_r;
  logic [15:0] result_r;
  logic        c_out_r;
  logic        ovf_r;
  logic        busy_r;
  logic        done_r;

  logic [3:0]  a_nib_s;
  logic [3:0]  b_nib_s;
  logic [3:0]  sum_nib_s;
  logic        nib_c_s;
  logic [15:0] final_sum_s;
  logic        ovf_s;

  // The one and only adder in the block; the carry register feeds its carry-in.
  adder4 u_adder4 (
    .a   (a_nib_s),
    .b   (b_nib_s),
    .i_c (carry_r),
    .sum (sum_nib_s),
    .o_c (nib_c_s)
  );

  // Select the operand nibbles addressed by the nibble counter.
  always_comb begin
    a_nib_s = 4'h0;
    b_nib_s = 4'h0;
    case (cnt_r)
      2'd0: begin
        a_nib_s = a_r[3:0];
        b_nib_s = b_r[3:0];
      end
      2'd1: begin
        a_nib_s = a_r[7:4];
        b_nib_s = b_r[7:4];
      end
      2'd2: begin
        a_nib_s = a_r[11:8];
        b_nib_s = b_r[11:8];
      end
      2'd3: begin
        a_nib_s = a_r[15:12];
        b_nib_s = b_r[15:12];
      end
      default: begin
        a_nib_s = 4'h0;
        b_nib_s = 4'h0;
      end
    endcase
  end

  // Full sum as it will look once the top nibble lands, and its overflow flag.
  always_comb begin
    final_sum_s = {sum_nib_s, acc_r[11:0]};
    ovf_s       = (a_r[15] == b_r[15]) && (final_sum_s[15] != a_r[15]);
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 2'd3) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus busy/done flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand capture, nibble-serial accumulation and final result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= 16'h0000;
      b_r      <= 16'h0000;
      carry_r  <= 1'b0;
      cnt_r    <= 2'd0;
      acc_r    <= 16'h0000;
      result_r <= 16'h0000;
      c_out_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= op_a;
            b_r     <= op_b;
            carry_r <= c_in;
            cnt_r   <= 2'd0;
          end
        end
        RUN: begin
          acc_r[{cnt_r, 2'b00} +: 4] <= sum_nib_s;
          carry_r                    <= nib_c_s;
          cnt_r                      <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            // Outputs change only here, so they never show a partial sum.
            result_r <= final_sum_s;
            c_out_r  <= nib_c_s;
            ovf_r    <= ovf_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign c_out  = c_out_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_add16_seq.sv
// tb_add16_seq: scoreboard bench for add16_seq. A reference process mirrors the
// request/acceptance timing at transaction level and queues the expected sum;
// a monitor on the falling edge pops and compares on every done pulse.
module tb_add16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c_out;
  logic        ovf;

  int total;
  int bad;
  int rem;          // edges still to pass before the next start can be taken
  int done_seen;
  logic prev_done;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];

  add16_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t e;
    int   u;
    int   s;
    u = int'(a) + int'(b) + int'(c);
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    e.res = u[15:0];
    e.co  = (u > 65535);
    e.ov  = (s > 32767) || (s < -32768);
    return e;
  endfunction

  // Reference: a start is taken only when the previous op has fully retired.
  initial begin
    rem = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        rem = 0;
        exp_q.delete();
      end else if (rem > 0) begin
        rem--;
      end else if (start) begin
        exp_q.push_back(ref_add(op_a, op_b, c_in));
        rem = 5;
      end
    end
  end

  // Monitor: busy/done timing every cycle, scoreboard compare on each done.
  initial begin
    exp_t e;
    prev_done = 1'b0;
    done_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("busy", {31'd0, busy}, {31'd0, (rem >= 2) ? 1'b1 : 1'b0});
        check("done", {31'd0, done}, {31'd0, (rem == 1) ? 1'b1 : 1'b0});
        if (prev_done && done) check("done_back_to_back", 32'd1, 32'd0);
        if (done) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("result", {16'd0, result}, {16'd0, e.res});
            check("c_out", {31'd0, c_out}, {31'd0, e.co});
            check("ovf", {31'd0, ovf}, {31'd0, e.ov});
          end
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // Issue a single start pulse, scramble operands afterwards, let it retire.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    c_in  = c;
    @(negedge clk);
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
    c_in  = 1'($urandom);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_result"}, {16'd0, result}, 32'd0);
    check({tag, "_c_out"}, {31'd0, c_out}, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    int done_before;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    op_a  = 16'h0000;
    op_b  = 16'h0000;
    c_in  = 1'b0;

    // Reset with no clock edge in between.
    #1 rst = 1'b1;
    #1 check_outputs_zero("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0);
    check("d1_result", {16'd0, result}, 32'h5555);
    check("d1_flags", {30'd0, c_out, ovf}, 32'd0);

    run_op(16'hFFFF, 16'h0000, 1'b1);
    check("d2_result", {16'd0, result}, 32'h0000);
    check("d2_flags", {30'd0, c_out, ovf}, 32'd2);

    run_op(16'h7FFF, 16'h0001, 1'b0);
    check("d3_result", {16'd0, result}, 32'h8000);
    check("d3_flags", {30'd0, c_out, ovf}, 32'd1);

    run_op(16'h8000, 16'h8000, 1'b0);
    check("d4_result", {16'd0, result}, 32'h0000);
    check("d4_flags", {30'd0, c_out, ovf}, 32'd3);

    run_op(16'h0FFF, 16'h0001, 1'b0);
    check("d5_result", {16'd0, result}, 32'h1000);
    // Outputs must hold while idle.
    repeat (3) @(negedge clk);
    check("hold_result", {16'd0, result}, 32'h1000);

    // Start held high with operands changing every cycle.
    done_before = done_seen;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      start = 1'b1;
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      c_in  = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("held_start_ops", 32'(done_seen - done_before), 32'd6);

    // Abort in RUN with cnt=2.
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'hABCD;
    op_b  = 16'h1111;
    c_in  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("abort");
    #1 rst = 1'b0;
    done_before = done_seen;
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_seen - done_before), 32'd0);
    run_op(16'h0005, 16'h0003, 1'b0);
    check("after_abort_result", {16'd0, result}, 32'h0008);

    // Random sequence of starts with random gaps.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 2) == 0);
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      c_in  = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add16_seq.md
ADD16_SEQ -- requirements
Module: add16_seq

Interface
REQ-001 Parameter: none; operand width fixed at 16 bits, nibble width 4 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled on clk rising edge only in IDLE.
REQ-005 op_a  input  16  operand A; sampled with an accepted start.
REQ-006 op_b  input  16  operand B; sampled with an accepted start.
REQ-007 c_in  input  1  carry-in; sampled with an accepted start.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle completion pulse, high while state is DONE.
REQ-010 result  output  16  registered sum, op_a + op_b + c_in mod 2^16.
REQ-011 c_out  output  1  registered carry out of bit 15.
REQ-012 ovf  output  1  registered two's-complement overflow flag.

Function
REQ-013 Block SHALL contain exactly one adder4 instance (ports a, b, i_c, sum, o_c) and SHALL compute the 16-bit sum nibble-serially through it; no other adder logic.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-015 IDLE: start=1 at edge -> latch op_a, op_b, c_in into internal registers, nibble counter := 0, go to RUN; start=0 -> stay IDLE.
REQ-016 RUN, each edge: adder4 fed nibble[cnt] of latched A and B, i_c = carry register (latched c_in for cnt=0); sum written to accumulator nibble[cnt]; carry register := o_c; cnt := cnt+1.
REQ-017 RUN edge with cnt=3: after processing nibble 3, copy accumulator to result, o_c to c_out, compute ovf, go to DONE.
REQ-018 ovf SHALL equal (A[15]==B[15]) and (sum[15]!=A[15]), using latched operands.
REQ-019 DONE: next edge -> IDLE unconditionally; done deasserts.
REQ-020 Latency: start accepted at edge E0 -> busy high after E0 for exactly 4 cycles; done high for the single cycle after E4; next start can be accepted at edge E6 (first edge in IDLE after DONE).
REQ-021 start asserted in RUN or DONE SHALL be ignored; it is not queued.
REQ-022 op_a, op_b, c_in changes after the accepting edge SHALL NOT affect the ongoing operation.
REQ-023 result, c_out, ovf SHALL hold their last values from DONE entry until the next DONE entry; they SHALL NOT show partial sums.
REQ-024 Carry SHALL propagate across all four nibbles, e.g. 0x0FFF + 0x0001 -> 0x1000.
REQ-025 Nibble counter SHALL be 2 bits; no wrap occurs outside RUN.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force state IDLE, cnt 0, carry register 0, accumulator 0, busy 0, done 0, result 0x0000, c_out 0, ovf 0.
REQ-027 rst during RUN or DONE SHALL abort the operation; no done pulse is produced for it.
REQ-028 After rst deasserts, the first start at a rising edge SHALL be accepted normally.

Verification
REQ-029 Bench SHALL cover these directed scenarios:
- rst pulse with no clock -> busy=0, done=0, result=0x0000, c_out=0, ovf=0.
- start, A=0x1234, B=0x4321, c_in=0 -> busy high 4 cycles, then done 1 cycle, result=0x5555, c_out=0, ovf=0.
- A=0xFFFF, B=0x0000, c_in=1 -> result=0x0000, c_out=1, ovf=0; carry ripples through all 4 nibbles.
- A=0x7FFF, B=0x0001, c_in=0 -> result=0x8000, c_out=0, ovf=1; then A=0x8000, B=0x8000 -> result=0x0000, c_out=1, ovf=1.
- start held high continuously, operands changed every cycle -> only starts at edges in IDLE accepted (every 6 cycles); each result matches its latched operands.
- rst asserted in RUN with cnt=2 -> outputs zero at once, no done pulse; next start A=0x0005, B=0x0003 -> result=0x0008.
REQ-030 Bench SHALL check result, c_out, ovf against a 17-bit reference sum on every done pulse, and check that done is never high in consecutive cycles.
